// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_seq multi-cycle ALU.
//   - state_e : FSM encoding (also driven out on the debug state port)
//   - OP_*    : opcode values carried on com
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Single-cycle ops occupy codes 0..7 so they can be decoded from com[2:0].
  localparam int unsigned OP_THA = 0;
  localparam int unsigned OP_THB = 1;
  localparam int unsigned OP_AND = 2;
  localparam int unsigned OP_OR  = 3;
  localparam int unsigned OP_SL  = 4;
  localparam int unsigned OP_SR  = 5;
  localparam int unsigned OP_ADD = 6;
  localparam int unsigned OP_SUB = 7;
  // Iterative ops.
  localparam int unsigned OP_SLN = 8;
  localparam int unsigned OP_SRN = 9;
  localparam int unsigned OP_MUL = 10;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU slice (opcodes 0..7).
// Ports:
//   a, b : operands (DATA_W)
//   op   : low three opcode bits
//   y    : result, modulo 2^DATA_W
//   cf   : carry (ADD), borrow (SUB), shifted-out bit (SL/SR), else 0
module alu_core
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              cf
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    // Top bit of the extended difference is the borrow (a < b).
    diff = {1'b0, a} - {1'b0, b};
    y    = '0;
    cf   = 1'b0;
    case (op)
      3'(OP_THA): y = a;
      3'(OP_THB): y = b;
      3'(OP_AND): y = a & b;
      3'(OP_OR):  y = a | b;
      3'(OP_SL): begin
        y  = {a[DATA_W-2:0], 1'b0};
        cf = a[DATA_W-1];
      end
      3'(OP_SR): begin
        y  = {1'b0, a[DATA_W-1:1]};
        cf = a[0];
      end
      3'(OP_ADD): begin
        y  = sum[DATA_W-1:0];
        cf = sum[DATA_W];
      end
      default: begin // OP_SUB
        y  = diff[DATA_W-1:0];
        cf = diff[DATA_W];
      end
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: eight single-cycle ops plus iterative SLN/SRN/MUL.
// Handshake: an operation is accepted on a rising edge where in_valid && in_ready
// (in_ready is high only in IDLE). The result is presented with out_valid held high
// and y/flags stable until a rising edge with out_ready high; the block returns to
// IDLE on the following cycle, so a new accept can occur one cycle later at the
// earliest. flush returns to IDLE from any state and wins over in_valid/out_ready.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; a, b, com sampled on accept
//   flush               : synchronous abort
//   out_valid/out_ready : result handshake
//   y, y_hi             : result (y_hi = MUL high half, else 0)
//   zf, cf, err         : zero, carry/borrow/shift-out/overflow, illegal opcode
//   dbg_state           : current FSM state (state_e encoding)
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SEL_W   = 4,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  com,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] y_hi,
  output logic              zf,
  output logic              cf,
  output logic              err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = SHAMT_W + 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;     // shift register / multiplicand
  logic [SEL_W-1:0]    com_q, com_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d; // {partial high, remaining multiplier bits}
  logic [DATA_W-1:0]   y_q, y_d;
  logic [DATA_W-1:0]   y_hi_q, y_hi_d;
  logic                zf_q, zf_d;
  logic                cf_q, cf_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   core_y;
  logic                core_cf;
  logic [SHAMT_W-1:0]  n;
  logic [DATA_W-1:0]   shifted;
  logic                shift_out;
  logic [DATA_W:0]     mul_add;
  logic [2*DATA_W-1:0] acc_step;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .a  (a),
    .b  (b),
    .op (com[2:0]),
    .y  (core_y),
    .cf (core_cf)
  );

  assign n = b[SHAMT_W-1:0];

  // One step of the iterative shift, direction chosen by the latched opcode.
  always_comb begin
    if (com_q == SEL_W'(OP_SLN)) begin
      shifted   = {a_q[DATA_W-2:0], 1'b0};
      shift_out = a_q[DATA_W-1];
    end else begin
      shifted   = {1'b0, a_q[DATA_W-1:1]};
      shift_out = a_q[0];
    end
  end

  // One shift-add step: add the multiplicand into the high half when the current
  // multiplier LSB is set, then shift the whole accumulator right (carry included).
  always_comb begin
    mul_add  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    acc_step = {mul_add, acc_q[DATA_W-1:1]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    com_d   = com_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    y_d     = y_q;
    y_hi_d  = y_hi_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    err_d   = err_q;

    if (flush) begin
      // Abort: result registers keep their last values.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_d   = a;
            com_d = com;
            if (com < SEL_W'(8)) begin
              y_d     = core_y;
              y_hi_d  = '0;
              zf_d    = (core_y == '0);
              cf_d    = core_cf;
              err_d   = 1'b0;
              state_d = ST_DONE;
            end else if (com == SEL_W'(OP_SLN) || com == SEL_W'(OP_SRN)) begin
              if (n == '0) begin
                y_d     = a;
                y_hi_d  = '0;
                zf_d    = (a == '0);
                cf_d    = 1'b0;
                err_d   = 1'b0;
                state_d = ST_DONE;
              end else begin
                cnt_d   = {1'b0, n};
                state_d = ST_RUN;
              end
            end else if (com == SEL_W'(OP_MUL)) begin
              acc_d   = {{DATA_W{1'b0}}, b};
              cnt_d   = CNT_W'(DATA_W);
              state_d = ST_RUN;
            end else begin
              y_d     = '0;
              y_hi_d  = '0;
              zf_d    = 1'b1;
              cf_d    = 1'b0;
              err_d   = 1'b1;
              state_d = ST_DONE;
            end
          end
        end

        ST_RUN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (com_q == SEL_W'(OP_MUL)) begin
            acc_d = acc_step;
            if (cnt_q == CNT_W'(1)) begin
              y_d     = acc_step[DATA_W-1:0];
              y_hi_d  = acc_step[2*DATA_W-1:DATA_W];
              zf_d    = (acc_step[DATA_W-1:0] == '0);
              cf_d    = |acc_step[2*DATA_W-1:DATA_W];
              err_d   = 1'b0;
              state_d = ST_DONE;
            end
          end else begin
            a_d = shifted;
            if (cnt_q == CNT_W'(1)) begin
              y_d     = shifted;
              y_hi_d  = '0;
              zf_d    = (shifted == '0);
              cf_d    = shift_out;
              err_d   = 1'b0;
              state_d = ST_DONE;
            end
          end
        end

        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      com_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      y_hi_q  <= '0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      com_q   <= com_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      y_hi_q  <= y_hi_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign y         = y_q;
  assign y_hi      = y_hi_q;
  assign zf        = zf_q;
  assign cf        = cf_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios followed by randomized ops,
// all checked against an arithmetic reference model.
module tb_alu_seq;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   com = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] y;
  logic [W-1:0] y_hi;
  logic         zf;
  logic         cf;
  logic         err;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  alu_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .com       (com),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_hi      (y_hi),
    .zf        (zf),
    .cf        (cf),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // Packed expectation: {y_hi, y, zf, cf, err}
  logic [2*W+2:0] exp_q[$];
  logic [2*W+2:0] last_out = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model from the arithmetic definition of each op.
  function automatic logic [2*W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [3:0] mc, output int lat);
    logic [31:0]  wide;
    logic [W-1:0] ry;
    logic [W-1:0] rh;
    logic         rc;
    logic         re;
    int           n;
    n    = int'(mb[3:0]);
    ry   = '0;
    rh   = '0;
    rc   = 1'b0;
    re   = 1'b0;
    lat  = 1;
    wide = '0;
    case (mc)
      4'd0: ry = ma;
      4'd1: ry = mb;
      4'd2: ry = ma & mb;
      4'd3: ry = ma | mb;
      4'd4: begin wide = 32'(ma) * 2; ry = wide[15:0]; rc = wide[16]; end
      4'd5: begin ry = ma / 2; rc = ma[0]; end
      4'd6: begin wide = 32'(ma) + 32'(mb); ry = wide[15:0]; rc = wide[16]; end
      4'd7: begin ry = ma - mb; rc = (ma < mb); end
      4'd8: begin
        wide = 32'(ma) << n;
        ry   = wide[15:0];
        rc   = (n == 0) ? 1'b0 : wide[16];
        lat  = n + 1;
      end
      4'd9: begin
        ry  = ma >> n;
        rc  = (n == 0) ? 1'b0 : ma[n-1];
        lat = n + 1;
      end
      4'd10: begin
        wide = 32'(ma) * 32'(mb);
        ry   = wide[15:0];
        rh   = wide[31:16];
        rc   = (rh != 0);
        lat  = W + 1;
      end
      default: re = 1'b1;
    endcase
    return {rh, ry, (ry == 0), rc, re};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic [3:0] oc, input int hold, input string tag);
    int             exp_lat;
    int             lat;
    logic [2*W+2:0] e;
    exp_q.push_back(model(oa, ob, oc, exp_lat));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    a = oa; b = ob; com = oc; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    e = exp_q.pop_front();
    last_out = e;
    check({tag, "_result"}, 64'({y_hi, y, zf, cf, err}), 64'(e));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); com = 4'($urandom);
      @(negedge clk);
      check({tag, "_hold_result"}, 64'({y_hi, y, zf, cf, err}), 64'(e));
      check({tag, "_hold_hs"}, 64'({out_valid, in_ready}), 64'(2'b10));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_back_idle"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask

  // Accept a MUL and stop during RUN cycle 5.
  task automatic start_mul_to_run5(input logic [W-1:0] oa, input logic [W-1:0] ob);
    a = oa; b = ob; com = 4'd10; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_quiet(input string tag);
    int seen;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check(tag, 64'(seen), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [2*W+2:0] e;
    int             dummy_lat;

    repeat (3) @(negedge clk);
    check("reset_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    check("reset_outputs", 64'({y_hi, y, zf, cf, err}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op(16'hFFFF, 16'h0001, 4'd6, 0, "add_wrap");
    run_op(16'd3, 16'd5, 4'd7, 0, "sub_borrow");
    run_op(16'h0100, 16'h0100, 4'd10, 0, "mul_256sq");
    run_op(16'h8001, 16'd4, 4'd8, 0, "sln4");
    run_op(16'h8001, 16'd0, 4'd8, 0, "sln0");
    run_op(16'h8421, 16'd15, 4'd9, 0, "srn15");
    run_op(W'($urandom), W'($urandom), 4'd6, 3, "backpressure");

    // Reset during MUL RUN cycle 5.
    start_mul_to_run5(16'h1234, 16'h5678);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_abort_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    check("rst_abort_outputs", 64'({y_hi, y, zf, cf, err}), 64'(0));
    rst_n = 1'b1;
    last_out = '0;
    expect_quiet("rst_abort_quiet");

    // Flush during MUL RUN cycle 5: outputs keep the previous result.
    run_op(16'h00F0, 16'd2, 4'd8, 0, "pre_flush_sln");
    start_mul_to_run5(16'hABCD, 16'h0003);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_abort_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    check("flush_abort_outputs", 64'({y_hi, y, zf, cf, err}), 64'(last_out));
    expect_quiet("flush_abort_quiet");

    run_op(16'h1234, 16'h4321, 4'hF, 0, "illegal_f");
    run_op(16'h1234, 16'h4321, 4'd11, 1, "illegal_b");

    // Flush in DONE together with out_ready: result kept, back to IDLE.
    e = model(16'h7000, 16'h9000, 4'd6, dummy_lat);
    a = 16'h7000; b = 16'h9000; com = 4'd6; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("done_flush_valid", 64'(out_valid), 64'(1));
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    check("done_flush_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    check("done_flush_outputs", 64'({y_hi, y, zf, cf, err}), 64'(e));

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
